// File: rtl/tron_bram.sv
// Collision and trail engine for two-player Tron: a 2^Y_W x 2^X_W visited-bit map
// in block RAM, checked and marked each time a player's head enters a new cell.
module tron_bram #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [X_W-1:0] p1_x,
  input  logic [Y_W-1:0] p1_y,
  input  logic [X_W-1:0] p2_x,
  input  logic [Y_W-1:0] p2_y,
  output logic           p1_lost,
  output logic           p2_lost
);

  localparam int COLS = 1 << X_W;
  localparam int ROWS = 1 << Y_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [X_W-1:0]    work_x_r, last1_x_r, last2_x_r;
  logic [Y_W-1:0]    work_y_r, last1_y_r, last2_y_r;
  logic              work_p_r, work_both_r;
  logic              first1_r, first2_r, last_srv_r;
  logic              p1_lost_r, p2_lost_r;
  logic [ROWS-1:0]   row_valid_r;
  logic [COLS-1:0]   q_r;
  logic [COLS-1:0]   mem_r [ROWS];

  logic              pend1_s, pend2_s, head_on_s, sel_p_s, hit_s;
  logic [COLS-1:0]   row_word_s, wr_word_s;

  assign p1_lost = p1_lost_r;
  assign p2_lost = p2_lost_r;

  // Move detection, player arbitration and next-state logic.
  always_comb begin
    pend1_s     = first1_r | ({p1_x, p1_y} != {last1_x_r, last1_y_r});
    pend2_s     = first2_r | ({p2_x, p2_y} != {last2_x_r, last2_y_r});
    head_on_s   = pend1_s & pend2_s & (p1_x == p2_x) & (p1_y == p2_y);
    sel_p_s     = 1'b0;
    state_nxt_s = state_r;
    if (pend1_s & pend2_s) begin
      sel_p_s = ~last_srv_r;
    end else if (pend2_s) begin
      sel_p_s = 1'b1;
    end else begin
      sel_p_s = 1'b0;
    end
    case (state_r)
      IDLE: begin
        if (pend1_s | pend2_s) begin
          state_nxt_s = READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ:    state_nxt_s = CHECK;
      CHECK:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Effective row word: an invalid row reads as all-zero, so reset clears the map instantly.
  always_comb begin
    if (row_valid_r[work_y_r]) begin
      row_word_s = q_r;
    end else begin
      row_word_s = {COLS{1'b0}};
    end
    hit_s               = row_word_s[work_x_r];
    wr_word_s           = row_word_s;
    wr_word_s[work_x_r] = 1'b1;
  end

  // Map RAM: synchronous read in READ, write-back in CHECK (state_r is forced to IDLE in reset).
  always_ff @(posedge clk) begin
    if (state_r == READ) begin
      q_r <= mem_r[work_y_r];
    end
    if (state_r == CHECK) begin
      mem_r[work_y_r] <= wr_word_s;
    end
  end

  // FSM state, work latches, per-player last positions and sticky lost flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      work_x_r    <= {X_W{1'b0}};
      work_y_r    <= {Y_W{1'b0}};
      work_p_r    <= 1'b0;
      work_both_r <= 1'b0;
      last1_x_r   <= {X_W{1'b0}};
      last1_y_r   <= {Y_W{1'b0}};
      last2_x_r   <= {X_W{1'b0}};
      last2_y_r   <= {Y_W{1'b0}};
      first1_r    <= 1'b1;
      first2_r    <= 1'b1;
      last_srv_r  <= 1'b1;
      p1_lost_r   <= 1'b0;
      p2_lost_r   <= 1'b0;
      row_valid_r <= {ROWS{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (head_on_s) begin
            work_x_r    <= p1_x;
            work_y_r    <= p1_y;
            work_p_r    <= 1'b0;
            work_both_r <= 1'b1;
            last1_x_r   <= p1_x;
            last1_y_r   <= p1_y;
            last2_x_r   <= p2_x;
            last2_y_r   <= p2_y;
            first1_r    <= 1'b0;
            first2_r    <= 1'b0;
            last_srv_r  <= sel_p_s;
          end else if (pend1_s | pend2_s) begin
            work_p_r    <= sel_p_s;
            work_both_r <= 1'b0;
            last_srv_r  <= sel_p_s;
            if (sel_p_s) begin
              work_x_r  <= p2_x;
              work_y_r  <= p2_y;
              last2_x_r <= p2_x;
              last2_y_r <= p2_y;
              first2_r  <= 1'b0;
            end else begin
              work_x_r  <= p1_x;
              work_y_r  <= p1_y;
              last1_x_r <= p1_x;
              last1_y_r <= p1_y;
              first1_r  <= 1'b0;
            end
          end
        end
        READ: begin
        end
        CHECK: begin
          row_valid_r[work_y_r] <= 1'b1;
          if (work_both_r) begin
            p1_lost_r <= 1'b1;
            p2_lost_r <= 1'b1;
          end else if (hit_s) begin
            if (work_p_r) begin
              p2_lost_r <= 1'b1;
            end else begin
              p1_lost_r <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tron_bram.sv
// Directed bench for tron_bram: a reference visited-map model pushes expected lost
// flags onto a scoreboard, which is popped and checked once the engine has settled.
module tb_tron_bram;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] p1_x = 8'd0, p2_x = 8'd0;
  logic [6:0] p1_y = 7'd0, p2_y = 7'd0;
  logic       p1_lost, p2_lost;

  int compared = 0;
  int mismatched = 0;

  string tag_q[$];
  logic  e1_q[$];
  logic  e2_q[$];

  // reference model state
  logic [255:0] vmap [128];
  logic [7:0]   m1x, m2x;
  logic [6:0]   m1y, m2y;
  logic         mf1, mf2, ml1, ml2;

  tron_bram #(.X_W(8), .Y_W(7)) dut (
    .clk(clk), .resetn(resetn),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_lost(p1_lost), .p2_lost(p2_lost)
  );

  always #10 clk = ~clk;

  task automatic model_clear();
    for (int r = 0; r < 128; r++) vmap[r] = 256'd0;
    mf1 = 1'b1; mf2 = 1'b1; ml1 = 1'b0; ml2 = 1'b0;
    m1x = 8'd0; m1y = 7'd0; m2x = 8'd0; m2y = 7'd0;
  endtask

  task automatic check_pop();
    string t;
    logic  e1, e2;
    t = tag_q.pop_front();
    e1 = e1_q.pop_front();
    e2 = e2_q.pop_front();
    compared++;
    assert (p1_lost === e1) else begin
      mismatched++;
      $error("FAIL %s p1_lost observed=%b expected=%b", t, p1_lost, e1);
    end
    compared++;
    assert (p2_lost === e2) else begin
      mismatched++;
      $error("FAIL %s p2_lost observed=%b expected=%b", t, p2_lost, e2);
    end
  endtask

  // Drive new heads, predict outcome with the model, then check after the 6-cycle worst case.
  task automatic apply(input logic [7:0] ax, input logic [6:0] ay,
                       input logic [7:0] bx, input logic [6:0] by,
                       input string tag, input int extra);
    logic pend1, pend2;
    @(negedge clk);
    p1_x = ax; p1_y = ay; p2_x = bx; p2_y = by;
    pend1 = mf1 || (ax != m1x) || (ay != m1y);
    pend2 = mf2 || (bx != m2x) || (by != m2y);
    if (pend1 && pend2 && ax == bx && ay == by) begin
      ml1 = 1'b1; ml2 = 1'b1;
      vmap[ay][ax] = 1'b1;
    end else begin
      if (pend1) begin
        if (vmap[ay][ax]) ml1 = 1'b1;
        vmap[ay][ax] = 1'b1;
      end
      if (pend2) begin
        if (vmap[by][bx]) ml2 = 1'b1;
        vmap[by][bx] = 1'b1;
      end
    end
    if (pend1) begin m1x = ax; m1y = ay; mf1 = 1'b0; end
    if (pend2) begin m2x = bx; m2y = by; mf2 = 1'b0; end
    tag_q.push_back(tag); e1_q.push_back(ml1); e2_q.push_back(ml2);
    repeat (6 + extra) @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic do_reset(input logic [7:0] ax, input logic [6:0] ay,
                          input logic [7:0] bx, input logic [6:0] by,
                          input string tag);
    @(negedge clk);
    resetn = 1'b0;
    p1_x = ax; p1_y = ay; p2_x = bx; p2_y = by;
    model_clear();
    tag_q.push_back(tag); e1_q.push_back(1'b0); e2_q.push_back(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_pop();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    model_clear();
    do_reset(8'd10, 7'd10, 8'd20, 7'd20, "reset1");
    apply(8'd10, 7'd10, 8'd20, 7'd20, "init_marks", 0);
    apply(8'd11, 7'd10, 8'd20, 7'd20, "p1_step11", 0);
    apply(8'd12, 7'd10, 8'd20, 7'd20, "p1_step12", 0);
    apply(8'd12, 7'd10, 8'd20, 7'd20, "p1_hold100", 100);
    apply(8'd12, 7'd10, 8'd12, 7'd20, "p2_other_row", 0);
    apply(8'd10, 7'd10, 8'd12, 7'd20, "p1_revisit", 0);
    apply(8'd10, 7'd10, 8'd11, 7'd10, "p2_on_trail", 0);
    apply(8'd13, 7'd11, 8'd13, 7'd21, "sticky_after_loss", 0);

    do_reset(8'd11, 7'd10, 8'd30, 7'd30, "reset2");
    apply(8'd11, 7'd10, 8'd30, 7'd30, "map_empty_again", 0);
    apply(8'd40, 7'd3, 8'd41, 7'd3, "same_row_pair", 0);
    apply(8'd11, 7'd10, 8'd40, 7'd3, "p2_same_row_hit", 0);

    do_reset(8'd60, 7'd60, 8'd70, 7'd70, "reset3");
    apply(8'd60, 7'd60, 8'd70, 7'd70, "init3", 0);
    apply(8'd50, 7'd50, 8'd50, 7'd50, "head_on", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
